// File: rtl/pp_seq_pkg.sv
// Shared types and elaboration helpers for the ping/pong turn-taking sequencer.
//   state_e : sequencer states
//   side_e  : which agent a grant belongs to
package pp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    PONG = 3'd2,
    PING = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_PING = 1'b0,
    SIDE_PONG = 1'b1
  } side_e;

  // Bits needed to hold max_val; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  // Down-counter preload so that a phase of `cycles` length (min 1) expires in its last cycle.
  function automatic int unsigned first_load(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/ping_pong_sequencer_if.sv
// Handshake bundle between the ping/pong agents and the sequencer.
//   start       : agents -> sequencer, start pulse
//   ping_ack    : agents -> sequencer, PING finished its turn
//   pong_ack    : agents -> sequencer, PONG finished its turn
//   ping_gnt    : sequencer -> agents, PING owns the resource
//   pong_gnt    : sequencer -> agents, PONG owns the resource
//   round_cnt   : completed PONG turns since the last accepted start
//   busy        : sequence in progress
//   done        : sequence ended (sticky)
//   timeout_err : watchdog fired (sticky)
interface ping_pong_sequencer_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             start;
  logic             ping_ack;
  logic             pong_ack;
  logic             ping_gnt;
  logic             pong_gnt;
  logic [CNT_W-1:0] round_cnt;
  logic             busy;
  logic             done;
  logic             timeout_err;

  modport master (
    output start, ping_ack, pong_ack,
    input  ping_gnt, pong_gnt, round_cnt, busy, done, timeout_err
  );

  modport slave (
    input  start, ping_ack, pong_ack,
    output ping_gnt, pong_gnt, round_cnt, busy, done, timeout_err
  );

endinterface

// File: rtl/pp_cycle_timer.sv
// Loadable down-counter with a registered expired flag (count == 0).
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : reload the counter with load_i (has priority over en_i)
//   load_i    : reload value
//   en_i      : count down by one, stopping at zero
//   expired_o : counter currently at zero
module pp_cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [W-1:0] load_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;
  logic         expired_q, expired_d;

  // Next count and its zero flag, so the flag is registered with the count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = load_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
    expired_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      expired_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ping_pong_sequencer.sv
// Turn-taking controller for two agents sharing one resource: after a start delay
// grants alternate PONG, PING, PONG ... until ROUNDS PONG turns completed, with an
// optional per-grant watchdog.
//   clk, rst : clock, synchronous active-high reset
//   pp_if    : slave side of the agent handshake bundle (start/acks in, grants/status out)
module ping_pong_sequencer
  import pp_seq_pkg::*;
#(
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned ROUNDS      = 10,
  parameter int unsigned TIMEOUT     = 0,
  parameter int unsigned CNT_W       = $clog2(ROUNDS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  ping_pong_sequencer_if.slave pp_if
);

  localparam int unsigned      TMR_MAX   = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
  localparam int unsigned      TMR_W     = timer_width(TMR_MAX);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(first_load(START_DELAY));
  localparam logic [TMR_W-1:0] WDOG_LOAD = TMR_W'(first_load(TIMEOUT));
  localparam logic [CNT_W-1:0] ROUNDS_C  = CNT_W'(ROUNDS);
  localparam bit               WDOG_EN   = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d, cnt_inc_c;
  logic             terr_q, terr_d;
  logic             ping_gnt_q, pong_gnt_q, busy_q, done_q;
  logic             tmr_clear_c, tmr_en_c, tmr_expired;
  logic [TMR_W-1:0] tmr_load_c;

  // One timer serves the start delay in WAIT and the watchdog in the grant states.
  pp_cycle_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear_c),
    .load_i    (tmr_load_c),
    .en_i      (tmr_en_c),
    .expired_o (tmr_expired)
  );

  // Saturating increment of the completed-turn count.
  assign cnt_inc_c = (round_cnt_q == ROUNDS_C) ? round_cnt_q : round_cnt_q + CNT_W'(1);
  assign tmr_en_c  = (state_q == WAIT) || (state_q == PONG) || (state_q == PING);

  // Next-state, counter and timer control.
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    terr_d      = terr_q;
    tmr_clear_c = 1'b0;
    tmr_load_c  = '0;

    case (state_q)
      IDLE, DONE: begin
        if (pp_if.start) begin
          state_d     = WAIT;
          round_cnt_d = '0;
          terr_d      = 1'b0;
        end
      end
      WAIT: begin
        if (tmr_expired) state_d = PONG;
      end
      PONG: begin
        // An ack in the expiry cycle still takes the normal handoff.
        if (pp_if.pong_ack) begin
          round_cnt_d = cnt_inc_c;
          state_d     = (cnt_inc_c == ROUNDS_C) ? DONE : PING;
        end else if (WDOG_EN && tmr_expired) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end
      end
      PING: begin
        if (pp_if.ping_ack) begin
          state_d = PONG;
        end else if (WDOG_EN && tmr_expired) begin
          state_d = DONE;
          terr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state change restarts the timer for the phase being entered.
    if (state_d != state_q) begin
      tmr_clear_c = 1'b1;
      tmr_load_c  = (state_d == WAIT) ? WAIT_LOAD : WDOG_LOAD;
    end
  end

  // State and registered outputs, decoded from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      terr_q      <= 1'b0;
      ping_gnt_q  <= 1'b0;
      pong_gnt_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      terr_q      <= terr_d;
      ping_gnt_q  <= (state_d == PING);
      pong_gnt_q  <= (state_d == PONG);
      busy_q      <= (state_d == WAIT) || (state_d == PONG) || (state_d == PING);
      done_q      <= (state_d == DONE);
    end
  end

  assign pp_if.ping_gnt    = ping_gnt_q;
  assign pp_if.pong_gnt    = pong_gnt_q;
  assign pp_if.round_cnt   = round_cnt_q;
  assign pp_if.busy        = busy_q;
  assign pp_if.done        = done_q;
  assign pp_if.timeout_err = terr_q;

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Self-checking bench for ping_pong_sequencer: directed vector table, handshake
// sequences, and random stimulus against a turn-level reference model.
module tb_ping_pong_sequencer;
  import pp_seq_pkg::*;

  localparam int SD = 100;
  localparam int RN = 10;
  localparam int TO = 8;
  localparam int CW = $clog2(RN + 1);
  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ping_pong_sequencer_if #(.CNT_W(CW)) pp_if ();

  ping_pong_sequencer #(
    .START_DELAY (SD),
    .ROUNDS      (RN),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pp_if (pp_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, remaining start delay, whose turn, turns done, grant age.
  bit    m_run   = 1'b0;
  bit    m_done  = 1'b0;
  bit    m_terr  = 1'b0;
  int    m_delay = 0;
  int    m_turns = 0;
  int    m_age   = 0;
  side_e m_turn  = SIDE_PONG;

  task automatic model_edge(input logic r, input logic s, input logic pa, input logic qa);
    if (r) begin
      m_run = 1'b0; m_done = 1'b0; m_terr = 1'b0;
      m_delay = 0; m_turns = 0; m_age = 0; m_turn = SIDE_PONG;
    end else if (!m_run) begin
      if (s) begin
        m_run = 1'b1; m_done = 1'b0; m_terr = 1'b0; m_turns = 0;
        m_delay = (SD == 0) ? 1 : SD;
      end
    end else if (m_delay > 0) begin
      m_delay--;
      if (m_delay == 0) begin
        m_turn = SIDE_PONG;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (m_turn == SIDE_PONG && qa) begin
        if (m_turns < RN) m_turns++;
        if (m_turns == RN) begin
          m_run = 1'b0; m_done = 1'b1;
        end else begin
          m_turn = SIDE_PING; m_age = 0;
        end
      end else if (m_turn == SIDE_PING && pa) begin
        m_turn = SIDE_PONG; m_age = 0;
      end else if (TO > 0 && m_age >= TO) begin
        m_run = 1'b0; m_done = 1'b1; m_terr = 1'b1;
      end
    end
  endtask

  task automatic check_cycle();
    logic          e_ping, e_pong;
    logic [CW-1:0] e_cnt;
    e_pong = m_run && (m_delay == 0) && (m_turn == SIDE_PONG);
    e_ping = m_run && (m_delay == 0) && (m_turn == SIDE_PING);
    e_cnt  = CW'(m_turns);
    n_tests++;
    if ({pp_if.busy, pp_if.ping_gnt, pp_if.pong_gnt, pp_if.done, pp_if.timeout_err, pp_if.round_cnt}
        !== {m_run, e_ping, e_pong, m_done, m_terr, e_cnt}) begin
      n_fail++;
      $display("FAIL model t=%0t got busy=%b ping=%b pong=%b done=%b terr=%b cnt=%0d want busy=%b ping=%b pong=%b done=%b terr=%b cnt=%0d",
               $time, pp_if.busy, pp_if.ping_gnt, pp_if.pong_gnt, pp_if.done, pp_if.timeout_err,
               pp_if.round_cnt, m_run, e_ping, e_pong, m_done, m_terr, e_cnt);
    end
    n_tests++;
    if (pp_if.ping_gnt && pp_if.pong_gnt) begin
      n_fail++;
      $display("FAIL grant_onehot t=%0t got ping=1 pong=1 want at most one", $time);
    end
  endtask

  // One clock: model consumes the inputs being driven, DUT is sampled 1 unit after the edge.
  task automatic step();
    model_edge(rst, pp_if.start, pp_if.ping_ack, pp_if.pong_ack);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    int   cyc;
    logic rst, start, ping_ack, pong_ack;
    logic busy, ping_gnt, pong_gnt, done, terr;
    int   cnt;
  } vec_t;

  vec_t vec [NV];

  // in = {rst,start,ping_ack,pong_ack}; out = {busy,ping_gnt,pong_gnt,done,timeout_err}
  function automatic vec_t mk(input int cyc, input logic [3:0] in, input logic [4:0] out, input int cnt);
    vec_t v;
    v.cyc = cyc;
    {v.rst, v.start, v.ping_ack, v.pong_ack} = in;
    {v.busy, v.ping_gnt, v.pong_gnt, v.done, v.terr} = out;
    v.cnt = cnt;
    return v;
  endfunction

  // Start a sequence and play both agents until done; acks either held or given in the grant's 2nd cycle.
  task automatic run_handshake(input bit hold, output int first, output int pongs,
                               output int pings, output int gcyc, output int cycles);
    bit prev_pg, prev_ig;
    pp_if.start = 1'b1; pp_if.ping_ack = 1'b0; pp_if.pong_ack = 1'b0;
    step();
    pp_if.start = 1'b0;
    first = -1; pongs = 0; pings = 0; gcyc = 0; cycles = 0;
    prev_pg = 1'b0; prev_ig = 1'b0;
    while (!pp_if.done && cycles < 1000) begin
      pp_if.pong_ack = hold ? 1'b1 : (pp_if.pong_gnt && prev_pg);
      pp_if.ping_ack = hold ? 1'b1 : (pp_if.ping_gnt && prev_ig);
      prev_pg = pp_if.pong_gnt;
      prev_ig = pp_if.ping_gnt;
      step();
      cycles++;
      if (pp_if.pong_gnt && !prev_pg) begin
        pongs++;
        if (first < 0) first = cycles;
      end
      if (pp_if.ping_gnt && !prev_ig) pings++;
      if (pp_if.pong_gnt || pp_if.ping_gnt) gcyc++;
    end
    pp_if.ping_ack = 1'b0; pp_if.pong_ack = 1'b0;
  endtask

  task automatic check_handshake(input string tag, input bit hold);
    int first, pongs, pings, gcyc, cycles;
    run_handshake(hold, first, pongs, pings, gcyc, cycles);
    chk({tag, "_bounded"}, int'(cycles < 1000), 1);
    chk({tag, "_first_pong"}, first, SD);
    chk({tag, "_pong_grants"}, pongs, RN);
    chk({tag, "_ping_grants"}, pings, RN - 1);
    chk({tag, "_grant_cycles"}, gcyc, hold ? (2 * RN - 1) : 2 * (2 * RN - 1));
    chk({tag, "_done"}, int'(pp_if.done), 1);
    chk({tag, "_round_cnt"}, int'(pp_if.round_cnt), RN);
    chk({tag, "_timeout_err"}, int'(pp_if.timeout_err), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_time_limit reached at t=%0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    pp_if.start = 1'b0; pp_if.ping_ack = 1'b0; pp_if.pong_ack = 1'b0;

    vec[0]  = mk(2,   4'b1000, 5'b00000, 0);   // reset
    vec[1]  = mk(1,   4'b0100, 5'b10000, 0);   // start accepted
    vec[2]  = mk(99,  4'b0000, 5'b10000, 0);   // still waiting
    vec[3]  = mk(1,   4'b0000, 5'b10100, 0);   // first pong grant after the delay
    vec[4]  = mk(1,   4'b0001, 5'b11000, 1);   // ack in first grant cycle hands off
    vec[5]  = mk(3,   4'b0101, 5'b11000, 1);   // wrong-side ack and start while busy ignored
    vec[6]  = mk(1,   4'b0010, 5'b10100, 1);
    vec[7]  = mk(5,   4'b0010, 5'b10100, 1);   // ping_ack during pong ignored
    vec[8]  = mk(1,   4'b0011, 5'b11000, 2);
    vec[9]  = mk(7,   4'b0011, 5'b10100, 5);   // held acks toggle every cycle
    vec[10] = mk(1,   4'b1011, 5'b00000, 0);   // reset during round 5
    vec[11] = mk(3,   4'b0000, 5'b00000, 0);
    vec[12] = mk(1,   4'b0100, 5'b10000, 0);
    vec[13] = mk(100, 4'b0000, 5'b10100, 0);
    vec[14] = mk(1,   4'b0001, 5'b11000, 1);
    vec[15] = mk(7,   4'b0000, 5'b11000, 1);   // ping unacked for 7 cycles
    vec[16] = mk(1,   4'b0000, 5'b00011, 1);   // 8th cycle: watchdog
    vec[17] = mk(5,   4'b0000, 5'b00011, 1);   // sticky
    vec[18] = mk(1,   4'b0100, 5'b10000, 0);   // start in DONE clears status
    vec[19] = mk(100, 4'b0000, 5'b10100, 0);
    vec[20] = mk(7,   4'b0000, 5'b10100, 0);
    vec[21] = mk(1,   4'b0001, 5'b11000, 1);   // ack in the expiry cycle wins
    vec[22] = mk(17,  4'b0011, 5'b10100, 9);
    vec[23] = mk(1,   4'b0011, 5'b00010, 10);  // tenth pong turn ends the sequence
    vec[24] = mk(3,   4'b0001, 5'b00010, 10);  // count holds at ROUNDS

    for (int i = 0; i < NV; i++) begin
      rst = vec[i].rst;
      pp_if.start = vec[i].start; pp_if.ping_ack = vec[i].ping_ack; pp_if.pong_ack = vec[i].pong_ack;
      repeat (vec[i].cyc) step();
      n_tests++;
      if ({pp_if.busy, pp_if.ping_gnt, pp_if.pong_gnt, pp_if.done, pp_if.timeout_err} !==
          {vec[i].busy, vec[i].ping_gnt, vec[i].pong_gnt, vec[i].done, vec[i].terr} ||
          int'(pp_if.round_cnt) != vec[i].cnt) begin
        n_fail++;
        $display("FAIL vec%0d got bgpdt=%b%b%b%b%b cnt=%0d want bgpdt=%b%b%b%b%b cnt=%0d", i,
                 pp_if.busy, pp_if.ping_gnt, pp_if.pong_gnt, pp_if.done, pp_if.timeout_err, pp_if.round_cnt,
                 vec[i].busy, vec[i].ping_gnt, vec[i].pong_gnt, vec[i].done, vec[i].terr, vec[i].cnt);
      end
    end
    rst = 1'b0; pp_if.start = 1'b0; pp_if.ping_ack = 1'b0; pp_if.pong_ack = 1'b0;

    // Full sequence from reset, again from DONE, then with acks held high.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_handshake("seq_reset", 1'b0);
    check_handshake("seq_restart", 1'b0);
    check_handshake("seq_held_acks", 1'b1);

    // Random agents, start and occasional reset against the model.
    for (int c = 0; c < 6000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      pp_if.start    = ($urandom_range(0, 29) == 0);
      pp_if.ping_ack = ($urandom_range(0, 2) == 0);
      pp_if.pong_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
